// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_e        : arbiter FSM encoding (IDLE, RMW)
//   PORT_I, PORT_D : requester IDs; also the bit index of each port in the
//                    req/gnt vectors of rr_arb2 and the value held in prio.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant decision (purely combinational).
//   req[1:0]  in  : request per port, indexed by PORT_I / PORT_D
//   enable    in  : grants are only issued while high
//   prio      in  : port that wins when both request
//   gnt[1:0]  out : one-hot (or zero) grant vector
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req[PORT_I] && (!req[PORT_D] || prio == PORT_I)) begin
        gnt[PORT_I] = 1'b1;
      end else if (req[PORT_D]) begin
        gnt[PORT_D] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction read port and a data load/store port onto a
// single-ported word memory with combinational read data.
//   clock, reset            : single clock, synchronous active-high reset
//   i_req/i_addr            : instruction read request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata  : grant, and read data one cycle after grant
//   d_req/d_we/d_be/d_addr/d_wdata : data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata  : grant, and load data one cycle after grant
//   mem_we/mem_addr/mem_wdata/mem_rdata : word memory interface
// Partial stores are done as read (grant cycle) then write (RMW cycle).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int WORDSIZE = 4,
  parameter int MEMSIZE  = 32 * 1024,
  localparam int AW = $clog2(MEMSIZE),
  localparam int DW = WORDSIZE * 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_req,
  input  logic [AW-1:0]       i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DW-1:0]       i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [WORDSIZE-1:0] d_be,
  input  logic [AW-1:0]       d_addr,
  input  logic [DW-1:0]       d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DW-1:0]       d_rdata,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata
);

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic [DW-1:0]       i_rdata_q, i_rdata_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]       d_rdata_q, d_rdata_d;
  logic [AW-1:0]       rmw_addr_q, rmw_addr_d;
  logic [WORDSIZE-1:0] rmw_be_q, rmw_be_d;
  logic [DW-1:0]       rmw_wdata_q, rmw_wdata_d;
  logic [DW-1:0]       rmw_old_q, rmw_old_d;
  logic [DW-1:0]       rmw_merged;
  logic [1:0]          req_vec, gnt_vec;
  logic                arb_en;

  // Byte-lane merge of the latched store data over the latched old word.
  for (genvar gi = 0; gi < WORDSIZE; gi++) begin : g_merge
    assign rmw_merged[8*gi +: 8] = rmw_be_q[gi] ? rmw_wdata_q[8*gi +: 8]
                                                : rmw_old_q[8*gi +: 8];
  end

  always_comb begin
    req_vec         = 2'b00;
    req_vec[PORT_I] = i_req;
    req_vec[PORT_D] = d_req;
  end

  // Grants only from IDLE and never while reset is asserted.
  assign arb_en = (state_q == IDLE) && !reset;

  rr_arb2 u_rr_arb2 (
    .req    (req_vec),
    .enable (arb_en),
    .prio   (prio_q),
    .gnt    (gnt_vec)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    i_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_be_d    = rmw_be_q;
    rmw_wdata_d = rmw_wdata_q;
    rmw_old_d   = rmw_old_q;
    i_gnt       = gnt_vec[PORT_I];
    d_gnt       = gnt_vec[PORT_D];
    mem_we      = 1'b0;
    mem_addr    = i_addr;
    mem_wdata   = d_wdata;

    if (state_q == RMW) begin
      // Reset abandons the pending write; the FSM register returns to IDLE.
      if (!reset) begin
        mem_we    = 1'b1;
        mem_addr  = rmw_addr_q;
        mem_wdata = rmw_merged;
      end
      state_d = IDLE;
    end else if (gnt_vec[PORT_I]) begin
      mem_addr   = i_addr;
      i_rvalid_d = 1'b1;
      i_rdata_d  = mem_rdata;
      prio_d     = PORT_D;
    end else if (gnt_vec[PORT_D]) begin
      mem_addr = d_addr;
      prio_d   = PORT_I;
      if (!d_we) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = mem_rdata;
      end else if (&d_be) begin
        mem_we = 1'b1;
      end else if (|d_be) begin
        // Read phase of a partial store: capture the old word now.
        rmw_addr_d  = d_addr;
        rmw_be_d    = d_be;
        rmw_wdata_d = d_wdata;
        rmw_old_d   = mem_rdata;
        state_d     = RMW;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      prio_q      <= PORT_I;
      i_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
      rmw_old_q   <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      i_rvalid_q  <= i_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_be_q    <= rmw_be_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_old_q   <= rmw_old_d;
    end
  end

  // A valid still in flight when reset arrives is suppressed immediately.
  assign i_rvalid = i_rvalid_q && !reset;
  assign d_rvalid = d_rvalid_q && !reset;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORDSIZE, default 4, bytes per memory word.
REQ-002 Parameter MEMSIZE, default 32*1024, memory size in bytes; AW = $clog2(MEMSIZE), DW = WORDSIZE*8.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_req  in  1  instruction port read request, held until granted.
REQ-006 i_addr  in  AW  instruction byte address; low $clog2(WORDSIZE) bits ignored.
REQ-007 i_gnt  out  1  instruction request accepted this cycle.
REQ-008 i_rvalid  out  1  instruction read data valid.
REQ-009 i_rdata  out  DW  instruction read data.
REQ-010 d_req  in  1  data port request, held with its qualifiers until granted.
REQ-011 d_we  in  1  data request is a store.
REQ-012 d_be  in  WORDSIZE  store byte enables; bit k selects bits 8k+7:8k.
REQ-013 d_addr  in  AW  data byte address; low bits ignored.
REQ-014 d_wdata  in  DW  store data, already lane-aligned.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_rvalid  out  1  data load data valid.
REQ-017 d_rdata  out  DW  data load data.
REQ-018 mem_we  out  1  write enable to the word memory.
REQ-019 mem_addr  out  AW  address to the word memory.
REQ-020 mem_wdata  out  DW  write data to the word memory.
REQ-021 mem_rdata  in  DW  combinational read data from the word memory (reflects mem_addr in the same cycle).

Function
REQ-022 At most one of i_gnt, d_gnt SHALL be high in any cycle; a grant only occurs in state IDLE.
REQ-023 With one requester active in IDLE, it SHALL be granted that cycle.
REQ-024 With both active, the port named by register prio SHALL win; after any grant, prio SHALL point to the other port.
REQ-025 Granted read (i or d with d_we=0): mem_addr = request address that cycle; mem_rdata SHALL be registered into the port's rdata, with rvalid high exactly one cycle later for one cycle.
REQ-026 rdata SHALL hold its last value while rvalid is low.
REQ-027 Granted store with d_be all ones: mem_we=1, mem_wdata=d_wdata in the grant cycle; state stays IDLE.
REQ-028 Granted store with d_be = 0: granted, no mem_we, no state change.
REQ-029 Granted store with partial d_be: grant cycle reads the word (mem_we=0), latches mem_rdata, address, d_be and d_wdata; state goes to RMW.
REQ-030 In RMW: mem_we=1, mem_addr = latched address, mem_wdata = latched d_wdata lanes where latched be=1, latched old word elsewhere; no grants; next state IDLE.
REQ-031 Stores SHALL never assert d_rvalid.
REQ-032 States: IDLE, RMW only; IDLE->RMW on partial store grant, RMW->IDLE unconditionally.
REQ-033 A request active in IDLE SHALL be granted within 3 cycles (worst case: the other port's partial store plus RMW).
REQ-034 A read in the cycle after RMW SHALL return the merged word.
REQ-035 When idle, mem_we=0 and mem_addr=i_addr.

Reset
REQ-036 On reset: state=IDLE, prio=instruction port, i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, RMW latches=0.
REQ-037 In a reset cycle: mem_we=0, no grants; an in-progress RMW SHALL be abandoned without writing, and a pending rvalid SHALL be dropped.

Structure
REQ-038 Shared package mem_pkg SHALL hold the state encoding (IDLE, RMW) and port-ID constants (PORT_I, PORT_D).
REQ-039 The two-way round-robin decision SHALL be one sub-module, rr_arb2 (req[1:0], enable, prio in; gnt[1:0] out), with prio update in mem_arbiter.
REQ-040 mem_arbiter SHALL connect directly to the word memory's clock, write_en, address, data_i and data_o ports.

Verification
REQ-041 Both ports read after reset, i_addr=0x10, d_addr=0x20 -> i_gnt cycle 0, d_gnt cycle 1; i_rvalid cycle 1, d_rvalid cycle 2 with the correct words.
REQ-042 Store 0xAABBCCDD, be=4'b0101, to a word holding 0x11223344 -> one read cycle, then an RMW write; a following load returns 0x11BB33DD.
REQ-043 Full store 0xDEADBEEF, be=4'hF, to 0x40 -> single mem_we cycle; a load from 0x40 next cycle returns 0xDEADBEEF.
REQ-044 Both ports requesting for 10 cycles -> grants alternate, starting with i after reset; no cycle has both grants.
REQ-045 reset asserted during RMW -> no mem_we that cycle, the target word is unchanged, and state=IDLE.
REQ-046 Store with be=0 while i_req is held -> d_gnt, no mem_we; i_gnt the next cycle.
